serial_adder_n: RTL

Bit-serial, parametrised two-operand adder and the sequential successor of the single-bit full adder. It latches two WIDTH-bit operands on a start request and adds them LSB-first through one full-adder cell, one bit per clock, with a carry flip-flop. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the arithmetic primitive for the multi-cycle datapath exercises of the practice sessions.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/fa_cell.sv | 15 +
 rtl/serial_adder_n.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational single-bit full adder used as the serial adder's datapath.
module fa_cell (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y,
    input  logic ci
);

    always_comb begin
        s = x ^ y ^ ci;
        c = (x & y) | (x & ci) | (y & ci);
    end

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned PW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    part;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             fa_s;
    logic             fa_c;

    // Subtraction folds into the load: B is stored inverted and the carry seeded with 1.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load     = sub ? ~b : b;
        carry_load = sub | cin;
`else
        b_load     = b;
        carry_load = cin;
`endif
    end

    fa_cell u_fa (
        .s  (fa_s),
        .c  (fa_c),
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry)
    );

    // On the last bit the carry register still holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            part  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        part  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    part  <= PW'({fa_s, part} >> 1);
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= {fa_s, part};
                        cout  <= fa_c;
                        ovf   <= carry ^ fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
